rps_move_collector: RTL

- Front-end for the rock-paper-scissors game. It collects each player's move, drives the start/done handshake into the game logic, and rearms for the next round.
- Each player raises a raw lock button. The block synchronizes and debounces it, then latches the 2-bit move from that player's switches.
- When both players have locked, it issues a one-cycle start and waits for done. It then holds the result for a fixed time and reopens collection.
- Sits between the pad inputs and the game logic's player1_choice/player2_choice/start/done ports.

---
 rtl/rps_game_if.sv | 21 ++
 rtl/rps_move_collector.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rps_game_if.sv
// Move/start/done handshake between the move collector and the game logic.
interface rps_game_if;
  logic [1:0] player1_choice;
  logic [1:0] player2_choice;
  logic       start;
  logic       done;

  modport master (
    output player1_choice,
    output player2_choice,
    output start,
    input  done
  );

  modport slave (
    input  player1_choice,
    input  player2_choice,
    input  start,
    output done
  );
endinterface

// File: rtl/rps_move_collector.sv
// Collects debounced player locks and moves, then runs the start/done round handshake.
//
// state     | meaning
// IDLE      | collecting locks; both locked moves to START
// START     | one-cycle start pulse to game logic
// WAIT_DONE | waiting for done, aborts after TIMEOUT_CYCLES
// HOLD      | result held for HOLD_CYCLES, then rearm
module rps_move_collector #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       p1_sw,
  input  logic [1:0]       p2_sw,
  input  logic             p1_lock_raw,
  input  logic             p2_lock_raw,
  rps_game_if.master       game,
  output logic             p1_locked,
  output logic             p2_locked,
  output logic             busy,
  output logic             illegal,
  output logic             timeout
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2((HOLD_CYCLES > 1) ? HOLD_CYCLES : 2);
  localparam int TW = $clog2((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_t;

  state_t        state;
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    lock_evt;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    sw [2];
  logic [1:0]    choice [2];
  logic [1:0]    locked;
  logic [TW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;
  logic          start_q;
  logic          busy_q;
  logic          illegal_q;
  logic          timeout_q;

  assign raw   = {p2_lock_raw, p1_lock_raw};
  assign sw[0] = p1_sw;
  assign sw[1] = p2_sw;

  // A lock event is a debounced rising edge, seen one cycle after the level flips.
  assign lock_evt = deb & ~deb_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_d      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      choice[0] <= '0;
      choice[1] <= '0;
      locked    <= '0;
      wait_cnt  <= '0;
      hold_cnt  <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          for (int i = 0; i < 2; i++) begin
            if (lock_evt[i]) begin
              timeout_q <= 1'b0;
              if (!locked[i]) begin
                if (sw[i] == 2'b11) begin
                  illegal_q <= 1'b1;
                end else begin
                  choice[i] <= sw[i];
                  locked[i] <= 1'b1;
                end
              end
            end
          end
          if (&locked) begin
            state   <= START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          state    <= WAIT_DONE;
          wait_cnt <= '0;
        end
        WAIT_DONE: begin
          if (game.done) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            locked    <= '0;
            choice[0] <= '0;
            choice[1] <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            locked    <= '0;
            choice[0] <= '0;
            choice[1] <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign game.player1_choice = choice[0];
  assign game.player2_choice = choice[1];
  assign game.start          = start_q;
  assign p1_locked           = locked[0];
  assign p2_locked           = locked[1];
  assign busy                = busy_q;
  assign illegal             = illegal_q;
  assign timeout             = timeout_q;

endmodule
